// File: rtl/code_conv_pkg.sv
// Shared constants, FSM encoding and range-check helper for the code converter scheduler.
package code_conv_pkg;

  localparam logic [1:0] SEL_BIN2GRAY = 2'b00;
  localparam logic [1:0] SEL_BCD2XS3  = 2'b01;
  localparam logic [1:0] SEL_GRAY2BIN = 2'b10;
  localparam logic [1:0] SEL_XS32BIN  = 2'b11;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] XS3_MIN = 4'd3;
  localparam logic [3:0] XS3_MAX = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2
  } state_e;

  // Flags inputs that are not legal codes for the selected source encoding.
  function automatic logic range_err(input logic [3:0] code, input logic [1:0] sel);
    case (sel)
      SEL_BCD2XS3: range_err = (code > BCD_MAX);
      SEL_XS32BIN: range_err = (code < XS3_MIN) || (code > XS3_MAX);
      default:     range_err = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/code_conv_rr_arbiter.sv
// Combinational round-robin pick: first asserted req_valid at or after rr_ptr, with wrap.
module code_conv_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    winner
);

  logic [ID_W:0] idx;

  // Scan farthest-first so the requester closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    grant  = '0;
    winner = '0;
    idx    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = {1'b0, rr_ptr} + (ID_W + 1)'(i);
      if (idx >= (ID_W + 1)'(NUM_REQ)) begin
        idx = idx - (ID_W + 1)'(NUM_REQ);
      end
      if (req_valid[idx[ID_W-1:0]]) begin
        winner = idx[ID_W-1:0];
      end
    end
    if (|req_valid) begin
      grant[winner] = 1'b1;
    end
  end

endmodule

// File: rtl/code_conv_scheduler.sv
// Time-shares one combinational 4-bit code converter among NUM_REQ requesters;
// one request in flight, response returned two cycles after accept over valid/ready.
module code_conv_scheduler
  import code_conv_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*4-1:0] req_code,
  input  logic [NUM_REQ*2-1:0] req_sel,
  output logic [3:0]           conv_code_in,
  output logic [1:0]           conv_select,
  input  logic [3:0]           conv_code_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [3:0]           rsp_code,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_err,
  output logic                 busy
);

  state_e state_q, state_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    winner;
  logic               accept;

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [3:0]      conv_code_q, conv_code_d;
  logic [1:0]      conv_sel_q, conv_sel_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [3:0]      rsp_code_q, rsp_code_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic            rsp_err_q, rsp_err_d;

  code_conv_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .winner    (winner)
  );

  assign accept = (state_q == IDLE) && (|req_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CONV;
      CONV:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE) ? grant : '0;
    busy      = (state_q != IDLE);
  end

  // Converter inputs only move on an accept so the combinational result is stable through CONV.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    conv_code_d = conv_code_q;
    conv_sel_d  = conv_sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_code_d  = rsp_code_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          conv_code_d = req_code[4*i +: 4];
          conv_sel_d  = req_sel[2*i +: 2];
        end
      end
      id_d     = winner;
      rr_ptr_d = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end
    if (state_q == CONV) begin
      rsp_valid_d = 1'b1;
      rsp_code_d  = conv_code_out;
      rsp_id_d    = id_q;
      rsp_err_d   = range_err(conv_code_q, conv_sel_q);
    end
    if ((state_q == RESP) && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      id_q        <= '0;
      conv_code_q <= '0;
      conv_sel_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_code_q  <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      conv_code_q <= conv_code_d;
      conv_sel_q  <= conv_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_code_q  <= rsp_code_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign conv_code_in = conv_code_q;
  assign conv_select  = conv_sel_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_code     = rsp_code_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_code_conv_scheduler.sv
// Bench for code_conv_scheduler with a behavioural converter on conv_* and a reference model.
module tb_code_conv_scheduler;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  logic [N*4-1:0] req_code;
  logic [N*2-1:0] req_sel;
  logic [3:0]   conv_code_in;
  logic [1:0]   conv_select;
  logic [3:0]   conv_code_out;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [3:0]   rsp_code;
  logic [1:0]   rsp_id;
  logic         rsp_err;
  logic         busy;

  int total = 0;
  int bad   = 0;

  int   ord [5] = '{0, 1, 2, 3, 0};
  int   gcount, last_cyc, stage, mlast, w, j;
  bit   pend [N];
  logic [3:0] pc [N];
  logic [1:0] ps [N];
  logic [3:0] ecode;
  logic [1:0] eid;
  logic       eerr;
  logic [31:0] exp_rdy;

  code_conv_scheduler #(.NUM_REQ(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_code      (req_code),
    .req_sel       (req_sel),
    .conv_code_in  (conv_code_in),
    .conv_select   (conv_select),
    .conv_code_out (conv_code_out),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_code      (rsp_code),
    .rsp_id        (rsp_id),
    .rsp_err       (rsp_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] conv_fn(input logic [3:0] c, input logic [1:0] s);
    logic [3:0] b;
    case (s)
      2'b00: conv_fn = c ^ (c >> 1);
      2'b01: conv_fn = c + 4'd3;
      2'b10: begin
        b[3] = c[3];
        b[2] = b[3] ^ c[2];
        b[1] = b[2] ^ c[1];
        b[0] = b[1] ^ c[0];
        conv_fn = b;
      end
      default: conv_fn = c - 4'd3;
    endcase
  endfunction

  always_comb conv_code_out = conv_fn(conv_code_in, conv_select);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entry and exit at 1 time unit after a rising edge.
  task automatic do_req(input int id, input logic [3:0] code, input logic [1:0] sel,
                        input logic [3:0] e_code, input logic e_err, input string tag);
    int cnt = 0;
    rsp_ready = 1'b1;
    req_valid = 4'(1 << id);
    req_code[4*id +: 4] = code;
    req_sel[2*id +: 2]  = sel;
    #1;
    while (req_ready == 0 && cnt < 20) begin
      tick();
      #1;
      cnt++;
    end
    chk({tag, "_rdy"}, req_ready, 1 << id);
    tick();
    req_valid = '0;
    #1;
    chk({tag, "_cin"}, conv_code_in, code);
    chk({tag, "_csel"}, conv_select, sel);
    chk({tag, "_early_vld"}, rsp_valid, 0);
    chk({tag, "_busy"}, busy, 1);
    tick();
    #1;
    chk({tag, "_vld"}, rsp_valid, 1);
    chk({tag, "_code"}, rsp_code, e_code);
    chk({tag, "_id"}, rsp_id, id);
    chk({tag, "_err"}, rsp_err, e_err);
    tick();
    #1;
    chk({tag, "_done"}, rsp_valid, 0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_code = '0;
    req_sel = '0;
    rsp_ready = 1'b0;
    #2;
    chk("rst_cin", conv_code_in, 0);
    chk("rst_csel", conv_select, 0);
    chk("rst_vld", rsp_valid, 0);
    chk("rst_code", rsp_code, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", req_ready, 0);
    tick();
    tick();
    rst = 1'b0;

    do_req(0, 4'b0101, 2'b00, 4'b0111, 1'b0, "b2g");
    do_req(1, 4'b0111, 2'b01, 4'b1010, 1'b0, "bcd7");
    do_req(2, 4'b1010, 2'b01, 4'b1101, 1'b1, "bcd10");
    do_req(3, 4'b1001, 2'b01, 4'b1100, 1'b0, "bcd9");
    do_req(1, 4'b1111, 2'b01, 4'b0010, 1'b1, "bcd15");
    do_req(1, 4'b1000, 2'b11, 4'b0101, 1'b0, "xs8");
    do_req(2, 4'b0001, 2'b11, 4'b1110, 1'b1, "xs1");
    do_req(0, 4'b0011, 2'b11, 4'b0000, 1'b0, "xs3");
    do_req(3, 4'b1100, 2'b11, 4'b1001, 1'b0, "xs12");
    do_req(1, 4'b1101, 2'b11, 4'b1010, 1'b1, "xs13");
    do_req(0, 4'b0010, 2'b11, 4'b1111, 1'b1, "xs2");
    do_req(2, 4'b0111, 2'b10, 4'b0101, 1'b0, "g2b");
    do_req(3, 4'b1111, 2'b10, 4'b1010, 1'b0, "g2b15");

    // Reset while a request from requester 2 sits in CONV.
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    req_code[11:8] = 4'b1011;
    req_sel[5:4] = 2'b11;
    #1;
    chk("mrst_rdy", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    #1;
    chk("mrst_conv_busy", busy, 1);
    chk("mrst_conv_cin", conv_code_in, 4'b1011);
    rst = 1'b1;
    #1;
    chk("mrst_cin", conv_code_in, 0);
    chk("mrst_csel", conv_select, 0);
    chk("mrst_vld", rsp_valid, 0);
    chk("mrst_code", rsp_code, 0);
    chk("mrst_id", rsp_id, 0);
    chk("mrst_err", rsp_err, 0);
    chk("mrst_busy", busy, 0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("mrst_no_rsp", rsp_valid, 0);
      chk("mrst_idle", busy, 0);
      tick();
    end

    // All requesters held valid: rotation from 0, one grant every 3 cycles.
    req_code = 16'h4321;
    req_sel = '0;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    gcount = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (req_ready != 0) begin
        chk("rr_order", req_ready, 1 << ord[gcount]);
        if (gcount > 0) chk("rr_gap", cyc - last_cyc, 3);
        last_cyc = cyc;
        gcount++;
      end
      if (gcount == 5) break;
      tick();
    end
    chk("rr_grants", gcount, 5);
    req_valid = '0;
    tick();

    // Backpressure: response held 5 cycles, requester 3 stays pending.
    rsp_ready = 1'b0;
    req_valid = 4'b1100;
    req_code[11:8] = 4'b0110;
    req_sel[5:4] = 2'b00;
    req_code[15:12] = 4'b1101;
    req_sel[7:6] = 2'b01;
    #1;
    chk("bp_rdy", req_ready, 4'b0100);
    tick();
    req_valid = 4'b1000;
    #1;
    chk("bp_conv_rdy", req_ready, 0);
    tick();
    #1;
    chk("bp_vld", rsp_valid, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      #1;
      chk("bp_hold_vld", rsp_valid, 1);
      chk("bp_hold_code", rsp_code, 4'b0101);
      chk("bp_hold_id", rsp_id, 2);
      chk("bp_hold_err", rsp_err, 0);
      chk("bp_hold_rdy", req_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    #1;
    chk("bp_release_rdy", req_ready, 4'b1000);
    chk("bp_release_vld", rsp_valid, 0);
    tick();
    req_valid = '0;
    #1;
    tick();
    #1;
    chk("bp_r3_vld", rsp_valid, 1);
    chk("bp_r3_code", rsp_code, 4'b0000);
    chk("bp_r3_id", rsp_id, 3);
    chk("bp_r3_err", rsp_err, 1);
    tick();
    #1;
    chk("bp_r3_idle", busy, 0);
    tick();

    // Randomized traffic against the reference model; last grant was 3.
    stage = 0;
    mlast = 3;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      pc[i] = '0;
      ps[i] = '0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pc[i] = 4'($urandom_range(0, 15));
          ps[i] = 2'($urandom_range(0, 3));
        end
        req_valid[i] = pend[i];
        req_code[4*i +: 4] = pc[i];
        req_sel[2*i +: 2] = ps[i];
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      w = -1;
      for (int k = 0; k < N; k++) begin
        j = (mlast + 1 + k) % N;
        if (pend[j] && w < 0) w = j;
      end
      exp_rdy = (stage == 0 && w >= 0) ? (32'd1 << w) : 32'd0;
      chk("rnd_rdy", req_ready, exp_rdy);
      chk("rnd_vld", rsp_valid, stage == 2);
      chk("rnd_busy", busy, stage != 0);
      if (stage == 2) begin
        chk("rnd_code", rsp_code, ecode);
        chk("rnd_id", rsp_id, eid);
        chk("rnd_err", rsp_err, eerr);
      end
      if (stage == 0) begin
        if (w >= 0) begin
          pend[w] = 1'b0;
          mlast = w;
          ecode = conv_fn(pc[w], ps[w]);
          eid = 2'(w);
          eerr = (ps[w] == 2'b01 && pc[w] > 4'd9) ||
                 (ps[w] == 2'b11 && (pc[w] < 4'd3 || pc[w] > 4'd12));
          stage = 1;
        end
      end else if (stage == 1) begin
        stage = 2;
      end else if (rsp_ready) begin
        stage = 0;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
